// File: rtl/ap_ctrl_pkg.sv
// Shared types and default sizing for the ap_ctrl_chain initiator.
package ap_ctrl_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int NUM_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ap_drv_state_e;

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// Command, kernel handshake and report signals of the ap_ctrl_chain initiator.
interface ap_ctrl_driver_if
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [NUM_W-1:0] cmd_count;
  logic             hold_continue;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             lat_valid;
  logic [CNT_W-1:0] lat_cycles;
  logic [NUM_W-1:0] lat_index;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] total_cycles;
  logic             err_spurious;

  modport master (
    input  cmd_valid, cmd_count, hold_continue, ap_ready, ap_done,
    output cmd_ready, ap_start, ap_continue, lat_valid, lat_cycles,
           lat_index, busy, finish, total_cycles, err_spurious
  );

  modport slave (
    output cmd_valid, cmd_count, hold_continue, ap_ready, ap_done,
    input  cmd_ready, ap_start, ap_continue, lat_valid, lat_cycles,
           lat_index, busy, finish, total_cycles, err_spurious
  );

endinterface

// File: rtl/ap_ts_fifo.sv
// Start-timestamp FIFO, first-word fall-through; extra pointer bit tells full from empty.
module ap_ts_fifo
  import ap_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_chain initiator: issues N kernel invocations, up to DEPTH in flight,
// and reports per-invocation start-to-done latency and total run cycles.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | issuing starts and consuming dones
//   DONE  | one-cycle finish pulse, then back to IDLE
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic              clock,
  input logic              reset_n,
  ap_ctrl_driver_if.master bus
);

  ap_drv_state_e    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_now, r_total, r_lat_cycles;
  logic [NUM_W-1:0] r_cmd_count, r_issue_cnt, r_done_cnt, r_lat_index;
  logic             r_ap_start, r_cmd_ready, r_busy, r_finish, r_lat_valid, r_err;

  logic             w_accept, w_ap_continue, w_push, w_pop, w_done_hs;
  logic             w_fifo_full, w_fifo_empty, w_full_nxt, w_ap_start_nxt;
  logic [CNT_W-1:0] w_fifo_dout;
  logic [NUM_W-1:0] w_count_nxt, w_issue_nxt, w_done_nxt;

  assign w_accept      = bus.cmd_valid && (r_state == IDLE);
  assign w_ap_continue = (r_state == RUN) && !bus.hold_continue;
  assign w_push        = r_ap_start && bus.ap_ready && !w_fifo_full;
  assign w_done_hs     = bus.ap_done && w_ap_continue;
  assign w_pop         = w_done_hs && !w_fifo_empty;

  assign w_count_nxt = w_accept ? bus.cmd_count : r_cmd_count;
  assign w_issue_nxt = w_accept ? '0 : r_issue_cnt + NUM_W'(w_push);
  assign w_done_nxt  = w_accept ? '0 : r_done_cnt + NUM_W'(w_pop);
  // FIFO occupancy always equals issued minus completed invocations
  assign w_full_nxt  = ((w_issue_nxt - w_done_nxt) == NUM_W'(DEPTH));

  ap_ts_fifo #(.WIDTH(CNT_W), .DEPTH(DEPTH)) u_ts_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_now),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .dout    (w_fifo_dout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = (bus.cmd_count == '0) ? DONE : RUN;
      RUN:  if (w_pop && (w_done_nxt == r_cmd_count)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_ap_start_nxt = (w_state_nxt == RUN) && (w_issue_nxt < w_count_nxt) && !w_full_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_now        <= '0;
      r_cmd_count  <= '0;
      r_issue_cnt  <= '0;
      r_done_cnt   <= '0;
      r_total      <= '0;
      r_ap_start   <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
      r_lat_valid  <= 1'b0;
      r_lat_cycles <= '0;
      r_lat_index  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_now       <= r_now + CNT_W'(1);
      r_cmd_count <= w_count_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_done_cnt  <= w_done_nxt;
      r_ap_start  <= w_ap_start_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_finish    <= (w_state_nxt == DONE);
      r_lat_valid <= w_pop;
      if (w_pop) begin
        r_lat_cycles <= r_now - w_fifo_dout;
        r_lat_index  <= r_done_cnt;
      end
      if (w_accept)            r_total <= '0;
      else if (r_state == RUN) r_total <= r_total + CNT_W'(1);
      if (w_accept)                      r_err <= 1'b0;
      else if (w_done_hs && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.ap_start     = r_ap_start;
  assign bus.ap_continue  = w_ap_continue;
  assign bus.lat_valid    = r_lat_valid;
  assign bus.lat_cycles   = r_lat_cycles;
  assign bus.lat_index    = r_lat_index;
  assign bus.busy         = r_busy;
  assign bus.finish       = r_finish;
  assign bus.total_cycles = r_total;
  assign bus.err_spurious = r_err;

endmodule
